// File: rtl/mem_if_unit.sv
// mem_if_unit -- memory interface unit: MAR/MDR pair plus a small access
// sequencer that runs one read or write on a handshake memory port.
//
// Parameters:
//   DATA_W  : data path / MDR width
//   ADDR_W  : MAR / memory address width
//   TIMEOUT : max access cycles waited for mem_ack (MEM_IF_TIMEOUT_EN only)
//
// Ports:
//   Clk       in   clock, all state changes on the rising edge
//   Reset_al  in   asynchronous active-low reset
//   LD_MAR    in   load MAR from bus_data (IDLE only)
//   LD_MDR    in   load MDR from bus_data (IDLE only)
//   bus_data  in   datapath bus value
//   start_rd  in   start a read at MAR (wins over start_wr)
//   start_wr  in   start a write of MDR to MAR
//   mem_rdata in   memory read data
//   mem_ack   in   memory completes the current access
//   MAR       out  address register
//   MDR       out  data register
//   mem_addr  out  = MAR
//   mem_wdata out  = MDR
//   mem_ce    out  access strobe (RD/WR)
//   mem_we    out  write strobe (WR)
//   busy      out  state is not IDLE
//   done      out  one-cycle completion pulse
//   err       out  one-cycle timeout pulse (with done)
//
// Build option: define MEM_IF_TIMEOUT_EN to abort accesses that see no
// mem_ack within TIMEOUT cycles. Without it the unit waits forever and err=0.

module mem_if_unit #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Reset_al,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic [DATA_W-1:0] bus_data,
  input  logic              start_rd,
  input  logic              start_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] MAR,
  output logic [DATA_W-1:0] MDR,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nx;

  logic              ld_mar_en;
  logic              ld_mdr_en;
  logic              cap_rdata;
  logic              tmo_hit;
  logic [ADDR_W-1:0] mar_load;

  // bus_data -> MAR width adaptation (zero-extend or truncate)
  generate
    if (ADDR_W > DATA_W) begin : g_mar_ext
      assign mar_load = {{(ADDR_W-DATA_W){1'b0}}, bus_data};
    end else if (ADDR_W < DATA_W) begin : g_mar_trunc
      assign mar_load = bus_data[ADDR_W-1:0];
    end else begin : g_mar_eq
      assign mar_load = bus_data;
    end
  endgenerate

`ifdef MEM_IF_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;
  logic             tmo_last;

  assign tmo_last = (tmo_cnt == CNT_W'(TIMEOUT - 1));

  // Held at zero in IDLE so every access starts counting from its first cycle.
  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else if (state == RD || state == WR) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      err_q <= 1'b0;
    end else begin
      err_q <= tmo_hit;
    end
  end

  assign err = err_q && (state == DONE);
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    done      = 1'b0;
    ld_mar_en = 1'b0;
    ld_mdr_en = 1'b0;
    cap_rdata = 1'b0;
    tmo_hit   = 1'b0;
    unique case (state)
      IDLE: begin
        ld_mar_en = LD_MAR;
        ld_mdr_en = LD_MDR;
        if (start_rd) begin
          state_nx = RD;
        end else if (start_wr) begin
          state_nx = WR;
        end
      end
      RD: begin
        mem_ce = 1'b1;
        if (mem_ack) begin
          cap_rdata = 1'b1;
          state_nx  = DONE;
        end
`ifdef MEM_IF_TIMEOUT_EN
        else if (tmo_last) begin
          tmo_hit  = 1'b1;
          state_nx = DONE;
        end
`endif
      end
      WR: begin
        mem_ce = 1'b1;
        mem_we = 1'b1;
        if (mem_ack) begin
          state_nx = DONE;
        end
`ifdef MEM_IF_TIMEOUT_EN
        else if (tmo_last) begin
          tmo_hit  = 1'b1;
          state_nx = DONE;
        end
`endif
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Loads are only enabled in IDLE, so MAR/MDR stay put during an access;
  // a load in the start cycle lands before the access state is entered.
  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      MAR <= '0;
    end else if (ld_mar_en) begin
      MAR <= mar_load;
    end
  end

  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      MDR <= '0;
    end else if (ld_mdr_en) begin
      MDR <= bus_data;
    end else if (cap_rdata) begin
      MDR <= mem_rdata;
    end
  end

  assign mem_addr  = MAR;
  assign mem_wdata = MDR;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_if_unit.sv
// tb_mem_if_unit -- randomized self-checking bench for mem_if_unit.
// A transaction-level model (current MAR/MDR values plus the expected
// access length) predicts the per-cycle memory port behaviour.
// Honours MEM_IF_TIMEOUT_EN the same way the design does.

module tb_mem_if_unit;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;
  localparam int unsigned TO = 4;

  logic          Clk;
  logic          Reset_al;
  logic          LD_MAR;
  logic          LD_MDR;
  logic [DW-1:0] bus_data;
  logic          start_rd;
  logic          start_wr;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [AW-1:0] MAR;
  logic [DW-1:0] MDR;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ce;
  logic          mem_we;
  logic          busy;
  logic          done;
  logic          err;

  mem_if_unit #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .TIMEOUT(TO)
  ) dut (
    .Clk      (Clk),
    .Reset_al (Reset_al),
    .LD_MAR   (LD_MAR),
    .LD_MDR   (LD_MDR),
    .bus_data (bus_data),
    .start_rd (start_rd),
    .start_wr (start_wr),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .MAR      (MAR),
    .MDR      (MDR),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ce   (mem_ce),
    .mem_we   (mem_we),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // reference model state
  logic [AW-1:0] m_mar;
  logic [DW-1:0] m_mdr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    LD_MAR    = 1'b0;
    LD_MDR    = 1'b0;
    bus_data  = '0;
    start_rd  = 1'b0;
    start_wr  = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  // random activity on every control input; the DUT must ignore it when busy
  task automatic drive_noise();
    LD_MAR   = 1'($urandom);
    LD_MDR   = 1'($urandom);
    bus_data = 16'($urandom);
    start_rd = 1'($urandom);
    start_wr = 1'($urandom);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},  busy,      0);
    check({tag, ".ce"},    mem_ce,    0);
    check({tag, ".we"},    mem_we,    0);
    check({tag, ".done"},  done,      0);
    check({tag, ".err"},   err,       0);
    check({tag, ".MAR"},   MAR,       m_mar);
    check({tag, ".MDR"},   MDR,       m_mdr);
    check({tag, ".addr"},  mem_addr,  m_mar);
    check({tag, ".wdata"}, mem_wdata, m_mdr);
  endtask

  task automatic check_access(input string tag, input bit is_wr);
    check({tag, ".busy"},  busy,      1);
    check({tag, ".ce"},    mem_ce,    1);
    check({tag, ".we"},    mem_we,    is_wr);
    check({tag, ".done"},  done,      0);
    check({tag, ".err"},   err,       0);
    check({tag, ".addr"},  mem_addr,  m_mar);
    check({tag, ".wdata"}, mem_wdata, m_mdr);
    check({tag, ".MDR"},   MDR,       m_mdr);
  endtask

  // One transaction. Optional MDR preload cycle, then a start cycle that may
  // also load MAR. mem_ack is raised in access cycle dly (0 = first cycle).
  task automatic access(input string tag, input bit is_wr, input bit extra_wr,
                        input bit ld_a, input logic [15:0] a,
                        input bit ld_d, input logic [15:0] dv,
                        input int unsigned dly, input logic [15:0] rd,
                        input bit noise);
    @(negedge Clk);
    check_idle({tag, ".pre"});
    if (ld_d) begin
      LD_MDR   = 1'b1;
      bus_data = dv;
      @(negedge Clk);
      m_mdr = dv;
      clear_inputs();
      check_idle({tag, ".ldmdr"});
    end
    LD_MAR   = ld_a;
    bus_data = a;
    start_rd = !is_wr;
    start_wr = is_wr || extra_wr;
    if (ld_a) m_mar = a;
    for (int unsigned k = 0; k <= dly; k++) begin
      @(negedge Clk);
      check_access({tag, ".acc"}, is_wr);
      clear_inputs();
      mem_ack   = (k == dly);
      mem_rdata = (k == dly) ? rd : 16'($urandom);
      if (noise) drive_noise();
    end
    @(negedge Clk);
    if (!is_wr) m_mdr = rd;
    check({tag, ".done"}, done,   1);
    check({tag, ".err"},  err,    0);
    check({tag, ".busy"}, busy,   1);
    check({tag, ".ce"},   mem_ce, 0);
    check({tag, ".we"},   mem_we, 0);
    check({tag, ".MDR"},  MDR,    m_mdr);
    check({tag, ".MAR"},  MAR,    m_mar);
    clear_inputs();
    if (noise) begin
      drive_noise();
      mem_ack = 1'($urandom);
    end
    @(negedge Clk);
    check_idle({tag, ".post"});
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    Reset_al = 1'b0;
    m_mar    = '0;
    m_mdr    = '0;
    #1;
    check_idle("reset");
    @(negedge Clk);
    @(negedge Clk);
    Reset_al = 1'b1;

    // directed read: zero-latency ack, done two cycles after start
    access("rd0", 1'b0, 1'b0, 1'b1, 16'h3000, 1'b0, 16'h0000, 0, 16'hBEEF, 1'b0);
    // directed write with 3-cycle ack delay -> 4 cycles of mem_we
    access("wr3", 1'b1, 1'b0, 1'b1, 16'h0042, 1'b1, 16'h1234, 3, 16'h0000, 1'b0);
    // both starts together: read wins; busy-time noise (incl. start_wr) ignored
    access("both", 1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000, 2, 16'hCAFE, 1'b1);
    // load+start in one cycle, LD_MDR=FFFF while busy must not stick
    @(negedge Clk);
    LD_MAR   = 1'b1;
    bus_data = 16'h0010;
    start_rd = 1'b1;
    m_mar    = 16'h0010;
    @(negedge Clk);
    check_access("ldst", 1'b0);
    clear_inputs();
    LD_MDR   = 1'b1;
    bus_data = 16'hFFFF;
    @(negedge Clk);
    check_access("ldbusy", 1'b0);
    clear_inputs();
    mem_ack   = 1'b1;
    mem_rdata = 16'h0ABC;
    @(negedge Clk);
    m_mdr = 16'h0ABC;
    check("ldbusy.done", done, 1);
    check("ldbusy.MDR",  MDR,  m_mdr);
    clear_inputs();
    @(negedge Clk);
    check_idle("ldbusy.post");

    // boundary: ack in the last allowed cycle completes normally
    access("ackedge", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, TO - 1, 16'h0000, 1'b0);

`ifdef MEM_IF_TIMEOUT_EN
    // read with no ack: TO access cycles, then done and err together
    @(negedge Clk);
    LD_MAR   = 1'b1;
    bus_data = 16'h7777;
    start_rd = 1'b1;
    m_mar    = 16'h7777;
    for (int unsigned k = 0; k < TO; k++) begin
      @(negedge Clk);
      check_access("tmo.acc", 1'b0);
      clear_inputs();
    end
    @(negedge Clk);
    check("tmo.done", done, 1);
    check("tmo.err",  err,  1);
    check("tmo.MDR",  MDR,  m_mdr);
    @(negedge Clk);
    check_idle("tmo.post");
`else
    // no timeout build: a long-silent memory just keeps the unit busy
    access("notmo", 1'b0, 1'b0, 1'b1, 16'h7777, 1'b0, 16'h0000, 20, 16'h5151, 1'b0);
`endif

    // randomized transactions
    for (int unsigned t = 0; t < 40; t++) begin
      bit          w;
      int unsigned d;
      w = 1'($urandom);
`ifdef MEM_IF_TIMEOUT_EN
      d = $urandom_range(TO - 1, 0);
`else
      d = $urandom_range(6, 0);
`endif
      access("rnd", w, (!w) && ($urandom_range(3, 0) == 0), 1'($urandom), 16'($urandom),
             1'($urandom), 16'($urandom), d, 16'($urandom), 1'b1);
    end

    // reset in the middle of a read
    @(negedge Clk);
    LD_MAR   = 1'b1;
    bus_data = 16'h5A5A;
    start_rd = 1'b1;
    m_mar    = 16'h5A5A;
    @(negedge Clk);
    clear_inputs();
    check("rst.ce_before", mem_ce, 1);
    #2;
    Reset_al = 1'b0;
    #1;
    m_mar = '0;
    m_mdr = '0;
    check("rst.ce",   mem_ce, 0);
    check("rst.busy", busy,   0);
    check("rst.MAR",  MAR,    0);
    check("rst.MDR",  MDR,    0);
    check("rst.done", done,   0);
    mem_ack   = 1'b1;
    mem_rdata = 16'h9999;
    @(negedge Clk);
    Reset_al = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge Clk);
      check_idle("rst.after");
    end
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_if_unit.md
MEM_IF_UNIT -- requirements
Module: mem_if_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data path and MDR width.
REQ-002 SHALL have parameter ADDR_W, default 16, MAR and memory address width.
REQ-003 SHALL have parameter TIMEOUT, default 15, the maximum number of access cycles waited for mem_ack; it is only used under MEM_IF_TIMEOUT_EN.
REQ-004 SHALL have port Clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset_al  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port LD_MAR  in  1  loads MAR from bus_data.
REQ-007 SHALL have port LD_MDR  in  1  loads MDR from bus_data.
REQ-008 SHALL have port bus_data  in  DATA_W  the datapath bus value.
REQ-009 SHALL have port start_rd  in  1  requests a read at MAR.
REQ-010 SHALL have port start_wr  in  1  requests a write of MDR to MAR.
REQ-011 SHALL have port mem_rdata  in  DATA_W  memory read data.
REQ-012 SHALL have port mem_ack  in  1  memory completes the current access.
REQ-013 SHALL have port MAR  out  ADDR_W  address register.
REQ-014 SHALL have port MDR  out  DATA_W  data register.
REQ-015 SHALL have port mem_addr  out  ADDR_W  equals MAR.
REQ-016 SHALL have port mem_wdata  out  DATA_W  equals MDR.
REQ-017 SHALL have port mem_ce  out  1  access strobe.
REQ-018 SHALL have port mem_we  out  1  write strobe.
REQ-019 SHALL have port busy  out  1  high whenever the state is not IDLE.
REQ-020 SHALL have port done  out  1  one-cycle completion pulse.
REQ-021 SHALL have port err  out  1  one-cycle timeout pulse.

Function
REQ-022 SHALL implement the FSM states IDLE, RD, WR and DONE.
REQ-023 SHALL, in IDLE, go to RD on start_rd, go to WR on start_wr alone, and ignore start_wr when start_rd is also high (read priority).
REQ-024 SHALL ignore start_rd and start_wr in every state other than IDLE.
REQ-025 SHALL honour LD_MAR and LD_MDR only in IDLE and ignore them while busy.
REQ-026 SHALL, when a load and a start occur in the same IDLE cycle, perform the load and use the newly loaded value for the access.
REQ-027 SHALL load MAR with bus_data zero-extended when ADDR_W > DATA_W, and truncated to the low ADDR_W bits when ADDR_W < DATA_W.
REQ-028 SHALL drive mem_ce=1 and mem_we=0 in RD.
REQ-029 SHALL, in RD, on mem_ack, capture mem_rdata into MDR and go to DONE.
REQ-030 SHALL drive mem_ce=1 and mem_we=1 in WR.
REQ-031 SHALL, in WR, go to DONE on mem_ack.
REQ-032 SHALL hold MAR and MDR stable throughout an access.
REQ-033 SHALL pulse done=1 for exactly one cycle in DONE and then return unconditionally to IDLE.
REQ-034 SHALL drive mem_ce, mem_we, done and err to 0 outside the states that assert them.
REQ-035 SHALL take 2 cycles from start to done with mem_ack already high in the first access cycle; each cycle of ack delay adds one cycle.
REQ-036 SHALL ignore mem_ack in IDLE and DONE.

Reset
REQ-037 SHALL, while Reset_al=0, asynchronously force state=IDLE, MAR=0, MDR=0 and the timeout counter to 0.
REQ-038 SHALL hold mem_ce=0, mem_we=0, busy=0, done=0 and err=0 while in reset.
REQ-039 SHALL abort an access in progress on reset mid-access, issue no done, and leave MDR=0.
REQ-040 SHALL leave reset on the first rising Clk edge after Reset_al rises.

Configuration
REQ-041 SHALL, when MEM_IF_TIMEOUT_EN is defined, count cycles spent in RD/WR, clearing the count on entry.
REQ-042 SHALL, under MEM_IF_TIMEOUT_EN, leave the access after TIMEOUT cycles without mem_ack, go to DONE, and pulse done and err together.
REQ-043 SHALL, under MEM_IF_TIMEOUT_EN, leave MDR unchanged on a read timeout.
REQ-044 SHALL treat mem_ack arriving in the timeout cycle as a normal completion with err=0.
REQ-045 SHALL, when MEM_IF_TIMEOUT_EN is undefined, wait indefinitely for mem_ack, tie err to 0, and compile no counter.

Verification
REQ-046 SHALL cover a read at defaults: LD_MAR with bus_data=16'h3000, then start_rd, with mem_ack=1 and mem_rdata=16'hBEEF -> mem_addr=16'h3000, mem_ce=1, mem_we=0 for 1 cycle, MDR=16'hBEEF, done pulses 2 cycles after start.
REQ-047 SHALL cover a write: LD_MAR 16'h0042 and LD_MDR 16'h1234, then start_wr with ack delayed 3 cycles -> mem_we=1 and mem_wdata=16'h1234 for 4 cycles, one done pulse, busy low after it.
REQ-048 SHALL cover simultaneous starts: start_rd=start_wr=1 in IDLE -> read only, mem_we stays 0; a start_wr pulsed while busy is ignored and produces no second access.
REQ-049 SHALL cover load in the same cycle as start: LD_MAR with bus_data=16'h0010 and start_rd in one cycle -> mem_addr=16'h0010; LD_MDR with bus_data=16'hFFFF asserted while busy -> MDR unchanged.
REQ-050 SHALL cover reset mid-read: Reset_al=0 during RD -> mem_ce drops immediately, MAR=MDR=0, no done.
REQ-051 SHALL cover timeout under MEM_IF_TIMEOUT_EN with TIMEOUT=4 and mem_ack never asserted -> done=err=1 on the same cycle after 4 RD cycles, MDR unchanged; without the macro, the same stimulus keeps busy=1 indefinitely.
